mmu_sync_drive_endpoint: RTL
============================

Name: mmu_sync_drive_endpoint

Overview:
- Clocked endpoint for the MMU asynchronous drive/free pipeline (cFifo-style click stages).
- TX side turns a synchronous valid/ready request into a 2-phase drive token with bundled data, and waits for the stage's free acknowledge.
- RX side takes the 2-phase driveNext token at the pipeline tail, presents the data as valid/ready, and returns freeNext when the data is consumed.
- Sits at the boundary between the clocked MMU control logic and an async cFifo chain; one instance covers both ends of a chain.

Parameters:
- DATA_W, 32, width of the bundled data in each direction.
- SYNC_STAGES, 2, flop stages synchronising each incoming async phase signal (min 2).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with MMU_EP_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset; the async chain shares the same rstn.
- s_valid  in  1  TX request valid.
- s_ready  out  1  TX can accept.
- s_data  in  DATA_W  TX payload.
- o_drive  out  1  2-phase drive to the first stage's i_drive.
- o_drive_data  out  DATA_W  bundled data, held stable while a token is outstanding.
- i_free  in  1  2-phase free from the first stage's o_free (async).
- i_driveNext  in  1  2-phase token from the last stage's o_driveNext (async).
- i_data  in  DATA_W  bundled data from the chain tail.
- o_freeNext  out  1  2-phase acknowledge to the last stage's i_freeNext.
- m_valid  out  1  RX data valid.
- m_ready  in  1  RX consumer ready.
- m_data  out  DATA_W  RX payload, registered.
- o_timeout  out  1  sticky watchdog flag; tied 0 unless MMU_EP_TIMEOUT_EN is defined.

Behaviour:
- Reset values: o_drive=0, o_freeNext=0, o_drive_data=0, m_valid=0, m_data=0, o_timeout=0, all sync flops 0. TX state is TX_IDLE; RX state is RX_WAIT.
- Phase events: an event is a change of a synchronised async input relative to its previous synchronised value (edge detect after SYNC_STAGES flops). Detection latency is SYNC_STAGES+1 clk after the async transition.
- TX_IDLE:
  - s_ready=1 (combinational from state).
  - On s_valid & s_ready: register o_drive_data<=s_data and o_drive<=~o_drive in the same edge, then go to TX_BUSY.
  - The toggle is visible 1 clk after the accept cycle.
- TX_BUSY:
  - s_ready=0; o_drive and o_drive_data are held.
  - A free event returns the FSM to TX_IDLE. Earliest next accept is the cycle after that.
  - At most one token is outstanding.
  - A free event in TX_IDLE is a protocol error and is ignored (no state change).
- RX_WAIT:
  - On a driveNext event: m_data<=i_data, m_valid<=1, go to RX_HOLD.
  - The bundled-data constraint is met because i_data has been stable for at least SYNC_STAGES clk.
- RX_HOLD:
  - m_valid=1 and m_data is held.
  - On m_ready: o_freeNext<=~o_freeNext, m_valid<=0, go to RX_WAIT.
  - A driveNext event while in RX_HOLD cannot occur by protocol (the chain waits for freeNext) and is ignored.
- TX and RX operate independently; simultaneous events on both sides are each handled in the same cycle.
- Back-to-back throughput per side: 1 token per (SYNC_STAGES+2+async round-trip) clk.
- Reset mid-operation forces all phases to 0. The chain resets on the same rstn, so phase parity realigns and no spurious event is generated after release.

Optional Feature:
- Macro: MMU_EP_TIMEOUT_EN.
- When defined:
  - A counter (clog2(TIMEOUT_CYCLES+1) bits) increments each clk in TX_BUSY and clears on entry to TX_IDLE.
  - When it reaches TIMEOUT_CYCLES, o_timeout sets and stays set until reset.
  - The counter saturates and the FSM keeps waiting.
- When undefined: no counter is built and o_timeout is constant 0.

Decomposition:
- Package mmu_ep_pkg holds:
  - the tx_state_t enum {TX_IDLE, TX_BUSY};
  - the rx_state_t enum {RX_WAIT, RX_HOLD};
  - the default constant SYNC_STAGES_DEF=2.
- One sub-module, mmu_phase_sync: SYNC_STAGES flop synchroniser plus previous-value flop, with outputs o_level and o_event. It is instantiated twice (i_free, i_driveNext).

Test Plan:
- Reset, then release: all outputs at reset values, s_ready=1. No events while i_free and i_driveNext are held at 0 for 20 clk.
- s_valid=1, s_data=0xA5A5_0001: o_drive goes 0->1 one clk after the accept and o_drive_data=0xA5A5_0001. s_ready=0 until i_free toggles, then s_ready=1 exactly SYNC_STAGES+1 clk after the toggle.
- i_data=0x1234_5678 then i_driveNext toggles with m_ready=0: m_valid=1 and m_data=0x1234_5678 after SYNC_STAGES+1 clk. Held for 10 clk. Raising m_ready gives one o_freeNext toggle and m_valid=0 the next clk.
- Simultaneous: TX accept and a driveNext event in the same cycle: both complete with no interaction. A stray i_free toggle in TX_IDLE causes no state change.
- rstn asserted while in TX_BUSY and RX_HOLD: outputs return to reset values immediately (async). After release a new transfer of 0xDEAD_BEEF succeeds.
- With MMU_EP_TIMEOUT_EN and TIMEOUT_CYCLES=16: withhold i_free, and o_timeout=1 at cycle 16 of TX_BUSY, staying set after a later free. Without the macro, o_timeout stays 0.

Source files
------------

// File: rtl/mmu_ep_pkg.sv
// Shared types and defaults for the MMU clocked/async drive-free endpoint.
package mmu_ep_pkg;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_t;

   typedef enum logic {
      RX_WAIT = 1'b0,
      RX_HOLD = 1'b1
   } rx_state_t;

   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/mmu_phase_sync.sv
// Synchroniser for a 2-phase async signal: SYNC_STAGES flops plus a previous-value
// flop, so every transition of the input becomes a one-cycle event.
module mmu_phase_sync
   import mmu_ep_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_async,
   output logic o_level,
   output logic o_event
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign o_level = sync_q[SYNC_STAGES-1];
   assign o_event = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/mmu_sync_drive_endpoint.sv
// Clocked endpoint for an async drive/free cFifo chain: valid/ready <-> 2-phase tokens.
// Optional TX watchdog enabled by defining MMU_EP_TIMEOUT_EN.
//
// state   | meaning
// TX_IDLE | no token outstanding, s_ready high
// TX_BUSY | drive token issued, waiting for the free phase to flip
// RX_WAIT | waiting for a driveNext phase flip from the chain tail
// RX_HOLD | m_data presented, waiting for the consumer; freeNext flips on take
module mmu_sync_drive_endpoint
   import mmu_ep_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              o_drive,
   output logic [DATA_W-1:0] o_drive_data,
   input  logic              i_free,
   input  logic              i_driveNext,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_freeNext,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              o_timeout
);

   tx_state_t         tx_state_q;
   rx_state_t         rx_state_q;
   logic              drive_q;
   logic [DATA_W-1:0] drive_data_q;
   logic              free_next_q;
   logic              m_valid_q;
   logic [DATA_W-1:0] m_data_q;

   logic free_lvl, free_evt;
   logic dnext_lvl, dnext_evt;
   logic unused_ok;

   mmu_phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_free (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (i_free),
      .o_level (free_lvl),
      .o_event (free_evt)
   );

   mmu_phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dnext (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (i_driveNext),
      .o_level (dnext_lvl),
      .o_event (dnext_evt)
   );

   // Only edges matter here; the synchronised levels are not needed.
   assign unused_ok = ^{free_lvl, dnext_lvl, (TIMEOUT_CYCLES != 0)};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state_q   <= TX_IDLE;
         drive_q      <= 1'b0;
         drive_data_q <= '0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               // A free flip here is a protocol error and is deliberately ignored.
               if (s_valid) begin
                  drive_q      <= ~drive_q;
                  drive_data_q <= s_data;
                  tx_state_q   <= TX_BUSY;
               end
            end
            TX_BUSY: begin
               if (free_evt) tx_state_q <= TX_IDLE;
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_state_q  <= RX_WAIT;
         free_next_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
      end else begin
         case (rx_state_q)
            RX_WAIT: begin
               if (dnext_evt) begin
                  m_data_q   <= i_data;
                  m_valid_q  <= 1'b1;
                  rx_state_q <= RX_HOLD;
               end
            end
            RX_HOLD: begin
               if (m_ready) begin
                  free_next_q <= ~free_next_q;
                  m_valid_q   <= 1'b0;
                  rx_state_q  <= RX_WAIT;
               end
            end
            default: rx_state_q <= RX_WAIT;
         endcase
      end
   end

   assign s_ready      = (tx_state_q == TX_IDLE);
   assign o_drive      = drive_q;
   assign o_drive_data = drive_data_q;
   assign o_freeNext   = free_next_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;

`ifdef MMU_EP_TIMEOUT_EN
   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic             timeout_q;

   always_comb begin
      busy_cnt_d = '0;
      if (tx_state_q == TX_BUSY && !free_evt) begin
         busy_cnt_d = (busy_cnt_q == CNT_MAX) ? busy_cnt_q : busy_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
         if (busy_cnt_d == CNT_MAX) timeout_q <= 1'b1;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

endmodule
